// File: rtl/sort_info_node.sv
// Seven-slot node buffer that loads seven nodes, sorts them by weight with
// an odd-even transposition network, and holds the sorted set until acked.
module sort_info_node #(
    parameter int SORT_PASSES = 7
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    input  logic [12:0] in_node,
    output logic        in_ready,
    output logic [12:0] info_node_1,
    output logic [12:0] info_node_2,
    output logic [12:0] info_node_3,
    output logic [12:0] info_node_4,
    output logic [12:0] info_node_5,
    output logic [12:0] info_node_6,
    output logic [12:0] info_node_7,
    output logic        out_valid,
    input  logic        out_ack
);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [2:0]  count, count_n;
    logic [3:0]  phase, phase_n;
    logic [12:0] slot   [1:7];
    logic [12:0] slot_n [1:7];
    logic        valid_n;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= LOAD;
            count     <= '0;
            phase     <= '0;
            out_valid <= 1'b0;
            for (int i = 1; i <= 7; i++) begin
                slot[i] <= '0;
            end
        end else begin
            state     <= state_n;
            count     <= count_n;
            phase     <= phase_n;
            out_valid <= valid_n;
            for (int i = 1; i <= 7; i++) begin
                slot[i] <= slot_n[i];
            end
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        phase_n = phase;
        valid_n = out_valid;
        for (int i = 1; i <= 7; i++) begin
            slot_n[i] = slot[i];
        end
        unique case (state)
            LOAD: begin
                valid_n = 1'b0;
                if (in_valid) begin
                    for (int i = 1; i <= 7; i++) begin
                        if (count == 3'(i - 1)) slot_n[i] = in_node;
                    end
                    count_n = count + 3'd1;
                    if (count == 3'd6) begin
                        state_n = SORT;
                        count_n = '0;
                        phase_n = '0;
                    end
                end
            end
            SORT: begin
                // Even phases pair (1,2)(3,4)(5,6); odd phases (2,3)(4,5)(6,7).
                for (int i = 1; i <= 6; i++) begin
                    if (((i % 2) == 1) == (phase[0] == 1'b0)) begin
                        if (slot[i][7:0] > slot[i+1][7:0]) begin
                            slot_n[i]   = slot[i+1];
                            slot_n[i+1] = slot[i];
                        end
                    end
                end
                if (phase == 4'(SORT_PASSES - 1)) begin
                    state_n = DONE;
                    phase_n = '0;
                end else begin
                    phase_n = phase + 4'd1;
                end
            end
            DONE: begin
                // out_valid rises one settle cycle after the last phase.
                valid_n = 1'b1;
                if (out_valid && out_ack) begin
                    state_n = LOAD;
                    valid_n = 1'b0;
                    count_n = '0;
                end
            end
            default: begin
                state_n = LOAD;
            end
        endcase
    end

    assign in_ready    = (state == LOAD);
    assign info_node_1 = slot[1];
    assign info_node_2 = slot[2];
    assign info_node_3 = slot[3];
    assign info_node_4 = slot[4];
    assign info_node_5 = slot[5];
    assign info_node_6 = slot[6];
    assign info_node_7 = slot[7];

endmodule

// File: tb/tb_sort_info_node.sv
// Directed and random checks of sort_info_node against a stable-sort model.
module tb_sort_info_node;

    typedef logic [12:0] set_t [7];

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_valid = 1'b0;
    logic [12:0] in_node = '0;
    logic        out_ack = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [12:0] info_node_1, info_node_2, info_node_3, info_node_4;
    logic [12:0] info_node_5, info_node_6, info_node_7;
    logic [12:0] got [7];

    int checks = 0;
    int errors = 0;

    sort_info_node #(.SORT_PASSES(7)) dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_node(in_node),
        .in_ready(in_ready),
        .info_node_1(info_node_1), .info_node_2(info_node_2),
        .info_node_3(info_node_3), .info_node_4(info_node_4),
        .info_node_5(info_node_5), .info_node_6(info_node_6),
        .info_node_7(info_node_7),
        .out_valid(out_valid), .out_ack(out_ack)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        got[0] = info_node_1;
        got[1] = info_node_2;
        got[2] = info_node_3;
        got[3] = info_node_4;
        got[4] = info_node_5;
        got[5] = info_node_6;
        got[6] = info_node_7;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] rnd_node();
        return {4'($urandom), 1'($urandom), 8'($urandom)};
    endfunction

    // Stable sort by weight: insertion that only passes strictly larger keys.
    task automatic ref_sort(input set_t n, output set_t s);
        s = n;
        for (int i = 1; i < 7; i++) begin
            logic [12:0] key;
            int j;
            key = s[i];
            j = i - 1;
            while (j >= 0 && s[j][7:0] > key[7:0]) begin
                s[j+1] = s[j];
                j--;
            end
            s[j+1] = key;
        end
    endtask

    task automatic chk_slots(input string tag, input set_t e);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s_slot%0d", tag, i + 1), 32'(got[i]), 32'(e[i]));
        end
    endtask

    task automatic load_set(input set_t n, input bit gapped, input bit hold);
        int i = 0;
        int g = 0;
        while (i < 7 && g < 64) begin
            @(negedge CLK);
            if (gapped && g[0]) begin
                in_valid = 1'b0;
                in_node  = rnd_node();
            end else begin
                in_valid = 1'b1;
                in_node  = n[i];
            end
            chk("load_ready", 32'(in_ready), 32'd1);
            if (in_valid && in_ready) i++;
            g++;
        end
        chk("load_count", i, 7);
        @(posedge CLK);
        #1;
        if (hold) in_node = rnd_node();
        else in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit hold);
        int n = 0;
        while (!out_valid && n < 40) begin
            chk("busy_ready", 32'(in_ready), 32'd0);
            @(posedge CLK);
            #1;
            n++;
            if (hold) in_node = rnd_node();
        end
        chk("latency", n, 8);
        chk("done_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic ack_set(input set_t e);
        @(negedge CLK);
        in_valid = 1'b0;
        out_ack  = 1'b1;
        @(posedge CLK);
        #1;
        out_ack = 1'b0;
        chk("ack_valid", 32'(out_valid), 32'd0);
        chk("ack_ready", 32'(in_ready), 32'd1);
        chk_slots("retain", e);
    endtask

    task automatic run_set(input string tag, input set_t n);
        set_t e;
        ref_sort(n, e);
        load_set(n, 1'b0, 1'b0);
        wait_valid(1'b0);
        chk_slots(tag, e);
        ack_set(e);
    endtask

    initial begin
        set_t n, e;
        logic [7:0] rev_w [7];
        logic [7:0] stab_w [7];
        rev_w  = '{8'h77, 8'h44, 8'h3D, 8'h2B, 8'h22, 8'h1C, 8'h1A};
        stab_w = '{8'h05, 8'h03, 8'h05, 8'h03, 8'h05, 8'h03, 8'h05};

        #3;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk_slots("rst", '{default: 13'd0});
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 7; i++) n[i] = {4'(i + 3), 1'($urandom), rev_w[i]};
        run_set("reverse", n);

        for (int i = 0; i < 7; i++) n[i] = {4'(i), 1'(i % 2), stab_w[i]};
        ref_sort(n, e);
        load_set(n, 1'b0, 1'b0);
        wait_valid(1'b0);
        chk_slots("stable", e);
        ack_set(e);

        for (int i = 0; i < 7; i++) n[i] = rnd_node();
        ref_sort(n, e);
        load_set(n, 1'b1, 1'b1);
        wait_valid(1'b1);
        repeat (3) begin
            @(posedge CLK);
            #1;
            in_node = rnd_node();
            chk("gap_done_ready", 32'(in_ready), 32'd0);
        end
        chk_slots("gapped", e);
        ack_set(e);

        for (int i = 0; i < 7; i++) n[i] = rnd_node();
        ref_sort(n, e);
        load_set(n, 1'b0, 1'b0);
        wait_valid(1'b0);
        repeat (20) begin
            @(posedge CLK);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        chk_slots("hold", e);
        ack_set(e);
        for (int i = 0; i < 7; i++) n[i] = rnd_node();
        run_set("rearm", n);

        for (int i = 0; i < 7; i++) n[i] = rnd_node();
        load_set(n, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk_slots("midrst", '{default: 13'd0});
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 7; i++) n[i] = rnd_node();
        run_set("after_rst", n);

        for (int i = 0; i < 6; i++) n[i] = {4'(i + 8), 1'(i % 2), 8'hFF};
        n[6] = {4'd2, 1'b1, 8'h00};
        run_set("boundary", n);

        repeat (4) begin
            for (int i = 0; i < 7; i++) n[i] = rnd_node();
            run_set("random", n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sort_info_node.md
SORT_INFO_NODE -- requirements
Module: sort_info_node

Interface
REQ-001 SHALL have parameter SORT_PASSES, default 7, giving the number of sort phases; legal range 7..15; fewer than 7 is not legal.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_node is valid this cycle.
REQ-005 SHALL have port in_node, input, 13 bits: [12:9] symbol id, [8] tag bit, [7:0] weight (sort key).
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_node this cycle.
REQ-007 SHALL have ports info_node_1..info_node_7, output, 13 bits each: node slots; after sorting, ascending by weight from 1 to 7.
REQ-008 SHALL have port out_valid, output, 1 bit: info_node_1..7 hold a completed sorted set.
REQ-009 SHALL have port out_ack, input, 1 bit: the downstream leaf selector has consumed the set.

Function
REQ-010 SHALL implement a 3-state FSM: LOAD, SORT, DONE.
REQ-011 In LOAD, SHALL drive in_ready=1, out_valid=0, and keep a 3-bit load count (0..7).
REQ-012 In LOAD, when in_valid=1, SHALL write in_node into slot (count+1) and increment count.
REQ-013 SHALL move to SORT on the edge that writes the 7th node, clearing count and the phase counter to 0.
REQ-014 In SORT, SHALL drive in_ready=0 and ignore in_valid and in_node entirely.
REQ-015 SORT SHALL last exactly SORT_PASSES cycles, one compare-exchange phase per cycle, with phase counter p = 0..SORT_PASSES-1.
REQ-016 When p is even, SHALL compare-exchange slot pairs (1,2), (3,4), (5,6); slot 7 holds.
REQ-017 When p is odd, SHALL compare-exchange slot pairs (2,3), (4,5), (6,7); slot 1 holds.
REQ-018 A pair SHALL swap only if weight[lower slot] > weight[upper slot], strictly.
REQ-019 Equal weights SHALL never swap, so the sort is stable with respect to load order.
REQ-020 A swap SHALL move all 13 bits of both nodes; symbol id and tag stay attached to their weight.
REQ-021 Weight comparison SHALL be unsigned 8-bit.
REQ-022 After phase SORT_PASSES-1, SHALL enter DONE with out_valid=1.
REQ-023 Latency: the 7th accept at edge k SHALL give out_valid=1 from edge k+SORT_PASSES+1; with the default, 8 cycles.
REQ-024 In DONE, info_node_1..7 and out_valid SHALL hold stable until out_ack=1.
REQ-025 In DONE, in_ready SHALL be 0.
REQ-026 In DONE with out_ack=1, SHALL return to LOAD on that edge with out_valid=0, in_ready=1, count=0.
REQ-027 On return to LOAD, slot contents SHALL be retained until overwritten.
REQ-028 out_ack outside DONE SHALL have no effect.
REQ-029 Outputs during LOAD and SORT are don't-care to the consumer; they SHALL reflect raw slot registers.
REQ-030 info_node_1..7 and out_valid SHALL be driven directly from registers, with no combinational path from inputs.
REQ-031 in_ready SHALL be decoded from state only.

Reset
REQ-032 When nRST=0, SHALL immediately (asynchronously) force state LOAD and zero count, phase counter, all seven slots and out_valid.
REQ-033 While nRST=0, SHALL drive in_ready=1.
REQ-034 Reset asserted during LOAD, SORT or DONE SHALL discard all partial data; the next accepted node after release goes to slot 1.

Verification
REQ-035 Reverse-order load: feed weights 0x77, 0x44, 0x3D, 0x2B, 0x22, 0x1C, 0x1A on consecutive cycles -> 8 cycles after the last accept, out_valid=1 and slots 1..7 weights = 1A, 1C, 22, 2B, 3D, 44, 77, with ids and tags carried.
REQ-036 Stability: feed ids 0..6 with weights 05, 03, 05, 03, 05, 03, 05 -> slot ids in order 1, 3, 5, 0, 2, 4, 6.
REQ-037 Gapped input with back-pressure: in_valid toggled every other cycle, then held high through SORT and DONE -> exactly 7 nodes accepted, in_ready=0 for all SORT and DONE cycles, extra beats not captured.
REQ-038 Hold and re-arm: keep out_ack=0 for 20 cycles in DONE -> outputs unchanged; pulse out_ack -> next edge out_valid=0, in_ready=1; a second set loads and sorts correctly.
REQ-039 Reset mid-operation: assert nRST=0 at SORT phase 3 -> all outputs 0 immediately; after release, a fresh 7-node load sorts correctly.
REQ-040 Boundary weights: all weights 0xFF except one 0x00 loaded last -> slot 1 weight 0x00, slots 2..7 weight 0xFF in load order.
